// File: rtl/icache_2way_pkg.sv
// icache_2way_pkg: shared constants, FSM state type and address helper for
// the 2-way instruction cache.
//   ICACHE_SETS / ICACHE_LINE_WORDS : default geometry (256 sets, 4 words)
//   RD_TYPE_WORD / RD_TYPE_LINE     : bus read type encodings
//   KSEG1_PREFIX                    : tag[19:17] value of uncached kseg1
//   state_t                         : controller states
//   phys_tag()                      : virtual tag -> physical tag
package icache_2way_pkg;

  localparam int         ICACHE_SETS       = 256;
  localparam int         ICACHE_LINE_WORDS = 4;
  localparam logic [2:0] RD_TYPE_WORD      = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE      = 3'b100;
  localparam logic [2:0] KSEG1_PREFIX      = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_RESP
  } state_t;

  // kseg0/kseg1 both map onto the low 512 MB, so the top three tag bits drop.
  function automatic logic [19:0] phys_tag(input logic [19:0] vtag);
    return {3'b000, vtag[16:0]};
  endfunction

endpackage

// File: rtl/icache_way_bank.sv
// icache_way_bank: storage for one cache way (valid bits, tags, line data).
// Ports:
//   clk                      clock
//   clear                    clears every valid bit and the read register
//   rd_en, rd_index          synchronous read of one set
//   rd_valid, rd_tag, rd_line registered read result (whole line)
//   word_we, wr_index, wr_word, wr_data   single-word data write
//   tag_we, wr_tag           writes tag at wr_index and marks the set valid
module icache_way_bank
  import icache_2way_pkg::*;
#(
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                              clk,
  input  logic                              clear,
  input  logic                              rd_en,
  input  logic [$clog2(SETS)-1:0]           rd_index,
  output logic                              rd_valid,
  output logic [19:0]                       rd_tag,
  output logic [LINE_WORDS-1:0][31:0]       rd_line,
  input  logic                              word_we,
  input  logic [$clog2(SETS)-1:0]           wr_index,
  input  logic [$clog2(LINE_WORDS)-1:0]     wr_word,
  input  logic [31:0]                       wr_data,
  input  logic                              tag_we,
  input  logic [19:0]                       wr_tag
);

  logic [SETS-1:0] valid;
  logic [19:0]     tags [SETS];
  logic [31:0]     data [SETS][LINE_WORDS];

  // Valid bits live in flops so the whole way can be invalidated in one cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tags[wr_index] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) begin
      data[wr_index][wr_word] <= wr_data;
    end
  end

  // The full line is read so the word select can use the buffered offset.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_valid <= 1'b0;
      rd_tag   <= '0;
      rd_line  <= '0;
    end else if (rd_en) begin
      rd_valid <= valid[rd_index];
      rd_tag   <= tags[rd_index];
      for (int w = 0; w < LINE_WORDS; w++) begin
        rd_line[w] <= data[rd_index][w];
      end
    end
  end

endmodule

// File: rtl/icache_2way.sv
// icache_2way: 2-way set-associative instruction cache with one LRU bit per
// set and an uncached single-word path for kseg1 fetches.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   inst_valid/op/index/tag/offset      fetch request from IF
//   inst_addr_ok                        request accepted this cycle
//   inst_data_ok, inst_rdata            returned instruction word
//   rd_req, rd_type, rd_addr, rd_rdy    bus read request handshake
//   ret_valid, ret_last, ret_data       bus return beats
module icache_2way
  import icache_2way_pkg::*;
#(
  parameter int SETS               = ICACHE_SETS,
  parameter int LINE_WORDS         = ICACHE_LINE_WORDS,
  parameter bit RESET_CLEARS_VALID = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic        inst_op,
  input  logic [7:0]  inst_index,
  input  logic [19:0] inst_tag,
  input  logic [3:0]  inst_offset,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam int WORD_W = $clog2(LINE_WORDS);

  state_t                       state;
  logic [19:0]                  req_tag;
  logic [7:0]                   req_index;
  logic [3:0]                   req_offset;
  logic                         req_uncached;
  logic [SETS-1:0]              lru;
  logic                         victim;
  logic [WORD_W-1:0]            beat_cnt;
  logic [31:0]                  captured;

  logic                         v0, v1;
  logic [19:0]                  t0, t1;
  logic [LINE_WORDS-1:0][31:0]  l0, l1;

  logic                         accept;
  logic [19:0]                  req_ptag;
  logic [WORD_W-1:0]            word_sel;
  logic                         hit0, hit1, lookup_hit;
  logic [31:0]                  hit_word;
  logic                         victim_pick;
  logic                         refill_beat, refill_done, capture_now;
  logic                         bank_clear;
  logic                         unused_op;

  // Every request is a read; the op bit carries no information.
  assign unused_op = inst_op;

  assign req_ptag    = phys_tag(req_tag);
  assign word_sel    = req_offset[WORD_W+1:2];
  assign hit0        = v0 && (t0 == req_ptag) && !req_uncached;
  assign hit1        = v1 && (t1 == req_ptag) && !req_uncached;
  assign lookup_hit  = (state == S_LOOKUP) && (hit0 || hit1);
  assign hit_word    = hit1 ? l1[word_sel] : l0[word_sel];
  assign victim_pick = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[req_index]);

  // Hits keep accepting so consecutive fetches stream one word per cycle.
  assign inst_addr_ok = !reset && ((state == S_IDLE) || lookup_hit);
  assign inst_data_ok = !reset && (lookup_hit || (state == S_RESP));
  assign inst_rdata   = reset      ? '0       :
                        lookup_hit ? hit_word :
                        (state == S_RESP) ? captured : '0;
  assign accept       = inst_addr_ok && inst_valid;

  assign refill_beat = !reset && (state == S_REFILL) && ret_valid;
  assign refill_done = refill_beat && ret_last;
  assign capture_now = req_uncached ? (beat_cnt == '0) : (beat_cnt == word_sel);
  assign bank_clear  = reset && RESET_CLEARS_VALID;

  // The bank read is launched with the live request index in the accept
  // cycle, so its registered result lines up with the LOOKUP cycle.
  icache_way_bank #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) bank0 (
    .clk      (clk),
    .clear    (bank_clear),
    .rd_en    (accept),
    .rd_index (inst_index),
    .rd_valid (v0),
    .rd_tag   (t0),
    .rd_line  (l0),
    .word_we  (refill_beat && !req_uncached && !victim),
    .wr_index (req_index),
    .wr_word  (beat_cnt),
    .wr_data  (ret_data),
    .tag_we   (refill_done && !req_uncached && !victim),
    .wr_tag   (req_ptag)
  );

  icache_way_bank #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) bank1 (
    .clk      (clk),
    .clear    (bank_clear),
    .rd_en    (accept),
    .rd_index (inst_index),
    .rd_valid (v1),
    .rd_tag   (t1),
    .rd_line  (l1),
    .word_we  (refill_beat && !req_uncached && victim),
    .wr_index (req_index),
    .wr_word  (beat_cnt),
    .wr_data  (ret_data),
    .tag_we   (refill_done && !req_uncached && victim),
    .wr_tag   (req_ptag)
  );

  // LRU bit names the way to evict next, i.e. the one not touched last.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (RESET_CLEARS_VALID) begin
        lru <= '0;
      end
    end else if (lookup_hit) begin
      lru[req_index] <= !hit1;
    end else if (refill_done && !req_uncached) begin
      lru[req_index] <= !victim;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      req_tag      <= '0;
      req_index    <= '0;
      req_offset   <= '0;
      req_uncached <= 1'b0;
      victim       <= 1'b0;
      beat_cnt     <= '0;
      captured     <= '0;
      rd_req       <= 1'b0;
      rd_type      <= '0;
      rd_addr      <= '0;
    end else begin
      if (accept) begin
        req_tag      <= inst_tag;
        req_index    <= inst_index;
        req_offset   <= inst_offset;
        req_uncached <= (inst_tag[19:17] == KSEG1_PREFIX);
      end
      unique case (state)
        S_IDLE: begin
          if (inst_valid) begin
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit0 || hit1) begin
            state <= inst_valid ? S_LOOKUP : S_IDLE;
          end else begin
            victim <= victim_pick;
            rd_req <= 1'b1;
            if (req_uncached) begin
              rd_type <= RD_TYPE_WORD;
              rd_addr <= {req_ptag, req_index, req_offset};
            end else begin
              rd_type <= RD_TYPE_LINE;
              rd_addr <= {req_ptag, req_index, 4'b0000};
            end
            state <= S_MISS;
          end
        end
        S_MISS: begin
          if (rd_rdy) begin
            rd_req   <= 1'b0;
            beat_cnt <= '0;
            state    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (ret_valid) begin
            beat_cnt <= beat_cnt + WORD_W'(1);
            if (capture_now) begin
              captured <= ret_data;
            end
            if (ret_last) begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// tb_icache_2way: self-checking bench for icache_2way. Expected instruction
// words are queued when a request is accepted and compared when the cache
// raises inst_data_ok. A background bus model answers reads unless a test
// takes over the bus to stall or abandon a refill.
module tb_icache_2way;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_op;
  logic [7:0]  inst_index;
  logic [19:0] inst_tag;
  logic [3:0]  inst_offset;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          accept_cycle = 0;
  int          last_resp_cycle = 0;
  int          resp_cyc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  logic        bus_enable = 1'b1;
  int          bus_reqs = 0;
  logic [2:0]  lat_type = '0;
  logic [31:0] lat_addr = '0;
  int          bus_beats;

  icache_2way dut (
    .clk          (clk),
    .reset        (reset),
    .inst_valid   (inst_valid),
    .inst_op      (inst_op),
    .inst_index   (inst_index),
    .inst_tag     (inst_tag),
    .inst_offset  (inst_offset),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .rd_req       (rd_req),
    .rd_type      (rd_type),
    .rd_addr      (rd_addr),
    .rd_rdy       (rd_rdy),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Memory contents as seen on the bus, keyed by physical address.
  function automatic logic [31:0] bus_data(input logic [31:0] a);
    if (a == 32'h1fc00000) return 32'h3c080001;
    if (a[31:4] == 28'h0000100) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return a ^ 32'hc0de0000;
  endfunction

  // Background bus slave: accepts immediately, returns 4 beats for a line
  // read and 1 beat for a word read.
  initial begin
    rd_rdy    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;
    forever begin
      @(posedge clk); #2;
      if (bus_enable && rd_req === 1'b1 && reset === 1'b0) begin
        lat_type = rd_type;
        lat_addr = rd_addr;
        bus_reqs++;
        rd_rdy = 1'b1;
        @(posedge clk); #2;
        rd_rdy = 1'b0;
        bus_beats = (lat_type == 3'b100) ? 4 : 1;
        for (int b = 0; b < bus_beats; b++) begin
          ret_valid = 1'b1;
          ret_last  = (b == bus_beats - 1);
          ret_data  = (bus_beats == 4) ? bus_data({lat_addr[31:4], 4'b0000} + 32'(4 * b))
                                       : bus_data(lat_addr);
          @(posedge clk); #2;
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
      end
    end
  end

  // Scoreboard side: every returned word must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && inst_data_ok === 1'b1) begin
      last_resp_cycle = cycle;
      resp_cyc_q.push_back(cycle);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL rdata_unexpected got=%h expected=none", inst_rdata);
      end else begin
        exp_word = exp_q.pop_front();
        if (inst_rdata !== exp_word) begin
          failures++;
          $display("[TB] FAIL rdata got=%h expected=%h", inst_rdata, exp_word);
        end
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic [31:0] exp_in);
    int guard;
    guard       = 0;
    inst_valid  = 1'b1;
    inst_tag    = addr[31:12];
    inst_index  = addr[11:4];
    inst_offset = addr[3:0];
    @(negedge clk);
    while (inst_addr_ok !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      failures++;
      $display("[TB] FAIL accept_timeout addr=%h got=no_addr_ok expected=addr_ok", addr);
    end
    accept_cycle = cycle;
    exp_q.push_back(exp_in);
    @(posedge clk); #2;
    inst_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_timeout pending=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    inst_valid  = 1'b1;
    inst_op     = 1'b0;
    inst_tag    = 20'h80001;
    inst_index  = 8'h00;
    inst_offset = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({inst_addr_ok, inst_data_ok, rd_req, rd_type, rd_addr, inst_rdata} !== 70'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b/%b/%b/%h/%h/%h expected=all_zero",
               inst_addr_ok, inst_data_ok, rd_req, rd_type, rd_addr, inst_rdata);
    end
    @(posedge clk); #2;
    reset      = 1'b0;
    inst_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_addr_ok got=%b expected=1", inst_addr_ok);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_uncached_boot();
    int n0;
    n0 = bus_reqs;
    send(32'hbfc00000, 32'h3c080001);
    wait_resp("boot");
    checks++;
    if (lat_type !== 3'b010) begin
      failures++;
      $display("[TB] FAIL boot_rd_type got=%b expected=010", lat_type);
    end
    checks++;
    if (lat_addr !== 32'h1fc00000) begin
      failures++;
      $display("[TB] FAIL boot_rd_addr got=%h expected=1fc00000", lat_addr);
    end
    checks++;
    if (last_resp_cycle - accept_cycle != 4) begin
      failures++;
      $display("[TB] FAIL boot_latency got=%0d expected=4", last_resp_cycle - accept_cycle);
    end
    send(32'hbfc00000, 32'h3c080001);
    wait_resp("boot_repeat");
    checks++;
    if (bus_reqs != n0 + 2) begin
      failures++;
      $display("[TB] FAIL boot_no_fill got=%0d expected=%0d", bus_reqs - n0, 2);
    end
  endtask

  task automatic test_cold_miss_hit();
    int n0;
    n0 = bus_reqs;
    send(32'h80001004, 32'h22);
    wait_resp("cold_miss");
    checks++;
    if (lat_type !== 3'b100 || lat_addr !== 32'h00001000) begin
      failures++;
      $display("[TB] FAIL line_read got=%b/%h expected=100/00001000", lat_type, lat_addr);
    end
    checks++;
    if (last_resp_cycle - accept_cycle != 7) begin
      failures++;
      $display("[TB] FAIL miss_latency got=%0d expected=7", last_resp_cycle - accept_cycle);
    end
    send(32'h8000100c, 32'h44);
    wait_resp("hit");
    checks++;
    if (last_resp_cycle - accept_cycle != 1) begin
      failures++;
      $display("[TB] FAIL hit_latency got=%0d expected=1", last_resp_cycle - accept_cycle);
    end
    checks++;
    if (bus_reqs != n0 + 1) begin
      failures++;
      $display("[TB] FAIL hit_no_bus got=%0d expected=1", bus_reqs - n0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = bus_reqs;
    resp_cyc_q.delete();
    inst_valid = 1'b1;
    inst_op    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_tag    = 20'h80001;
      inst_index  = 8'h00;
      inst_offset = 4'(4 * i);
      @(negedge clk);
      checks++;
      if (inst_addr_ok !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_addr_ok[%0d] got=%b expected=1", i, inst_addr_ok);
      end
      exp_q.push_back(32'h11 * 32'(i + 1));
      @(posedge clk); #2;
    end
    inst_valid = 1'b0;
    inst_op    = 1'b0;
    wait_resp("stream");
    checks++;
    if (resp_cyc_q.size() != 4 || resp_cyc_q[resp_cyc_q.size()-1] - resp_cyc_q[0] != 3) begin
      failures++;
      $display("[TB] FAIL stream_consecutive got=%0d_responses expected=4_in_4_cycles", resp_cyc_q.size());
    end
    checks++;
    if (bus_reqs != n0) begin
      failures++;
      $display("[TB] FAIL stream_no_bus got=%0d expected=0", bus_reqs - n0);
    end
  endtask

  task automatic test_lru_replace();
    int n0;
    n0 = bus_reqs;
    send(32'h80002000, bus_data(32'h00002000));
    wait_resp("fill_way1");
    send(32'h80001000, 32'h11);
    wait_resp("hit_way0");
    checks++;
    if (last_resp_cycle - accept_cycle != 1) begin
      failures++;
      $display("[TB] FAIL lru_hit_way0 got=%0d expected=1", last_resp_cycle - accept_cycle);
    end
    send(32'h80003000, bus_data(32'h00003000));
    wait_resp("evict");
    send(32'h80001000, 32'h11);
    wait_resp("survivor");
    checks++;
    if (bus_reqs != n0 + 2 || last_resp_cycle - accept_cycle != 1) begin
      failures++;
      $display("[TB] FAIL lru_survivor got=%0d_reads/%0d_cycles expected=2/1",
               bus_reqs - n0, last_resp_cycle - accept_cycle);
    end
    send(32'h80002000, bus_data(32'h00002000));
    wait_resp("evicted");
    checks++;
    if (bus_reqs != n0 + 3) begin
      failures++;
      $display("[TB] FAIL lru_evicted got=%0d expected=3", bus_reqs - n0);
    end
  endtask

  task automatic test_bus_stall();
    int guard;
    bus_enable = 1'b0;
    send(32'h80005010, bus_data(32'h00005010));
    guard = 0;
    @(negedge clk);
    while (rd_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rd_req, rd_type, rd_addr, inst_addr_ok} !== {1'b1, 3'b100, 32'h00005010, 1'b0}) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d] got=%b/%b/%h/%b expected=1/100/00005010/0",
                 i, rd_req, rd_type, rd_addr, inst_addr_ok);
      end
      @(negedge clk);
    end
    rd_rdy = 1'b1;
    @(posedge clk); #2;
    rd_rdy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ret_valid = 1'b1;
      ret_last  = (b == 3);
      ret_data  = bus_data(32'h00005010 + 32'(4 * b));
      @(posedge clk); #2;
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    wait_resp("stall");
    checks++;
    if (last_resp_cycle - accept_cycle != 12) begin
      failures++;
      $display("[TB] FAIL stall_latency got=%0d expected=12", last_resp_cycle - accept_cycle);
    end
    bus_enable = 1'b1;
  endtask

  task automatic test_reset_mid_refill();
    int guard;
    int n0;
    bus_enable = 1'b0;
    send(32'h80006020, bus_data(32'h00006020));
    guard = 0;
    @(negedge clk);
    while (rd_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    rd_rdy = 1'b1;
    @(posedge clk); #2;
    rd_rdy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ret_valid = 1'b1;
      ret_last  = 1'b0;
      ret_data  = bus_data(32'h00006020 + 32'(4 * b));
      @(posedge clk); #2;
    end
    ret_valid = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({inst_addr_ok, inst_data_ok, rd_req, rd_type, rd_addr, inst_rdata} !== 70'd0) begin
      failures++;
      $display("[TB] FAIL midrefill_reset got=%b/%b/%b/%h/%h/%h expected=all_zero",
               inst_addr_ok, inst_data_ok, rd_req, rd_type, rd_addr, inst_rdata);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrefill_idle got=%b/%b expected=1/0", inst_addr_ok, inst_data_ok);
    end
    @(posedge clk); #2;
    bus_enable = 1'b1;
    n0 = bus_reqs;
    send(32'h80006020, bus_data(32'h00006020));
    wait_resp("refetch");
    checks++;
    if (bus_reqs != n0 + 1 || lat_type !== 3'b100 || lat_addr !== 32'h00006020) begin
      failures++;
      $display("[TB] FAIL refetch_line got=%0d/%b/%h expected=1/100/00006020",
               bus_reqs - n0, lat_type, lat_addr);
    end
    checks++;
    if (last_resp_cycle - accept_cycle != 7) begin
      failures++;
      $display("[TB] FAIL refetch_latency got=%0d expected=7", last_resp_cycle - accept_cycle);
    end
  endtask

  initial begin
    $display("[TB] icache_2way bench start");
    test_reset();
    test_uncached_boot();
    test_cold_miss_hit();
    test_back_to_back();
    test_lru_replace();
    test_bus_stall();
    test_reset_mid_refill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
